// File: rtl/iic_poll_reader.sv
// Periodic block reader in front of iic_drive: reads NUM_REGS registers per poll period into a FWFT result FIFO.
// Optional IIC_POLL_ROUND_STAMP_EN prefixes each FIFO entry with a 16-bit round number.
`timescale 1ns/1ps

module iic_poll_reader #(
    parameter logic [7:0]  DEV_ADDR   = 8'h78,
    parameter logic [15:0] REG_BASE   = 16'h3000,
    parameter int          NUM_REGS   = 4,
    parameter int          POLL_DIV   = 80000,
    parameter int          TIMEOUT    = 20000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                            clk_8m,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic                            busy,
    input  logic                            err,
    input  logic [7:0]                      rd_data,
    output logic                            start_en,
    output logic                            wr_rd_flag,
    output logic [7:0]                      i2c_device_addr,
    output logic [15:0]                     register,
    output logic [7:0]                      data_byte,
    input  logic                            fifo_rd,
`ifdef IIC_POLL_ROUND_STAMP_EN
    output logic [39:0]                     fifo_dout,
`else
    output logic [23:0]                     fifo_dout,
`endif
    output logic                            fifo_empty,
    output logic                            fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [7:0]                      err_cnt,
    output logic [7:0]                      overflow_cnt,
    output logic                            poll_active
);

`ifdef IIC_POLL_ROUND_STAMP_EN
    localparam int EW = 40;
`else
    localparam int EW = 24;
`endif
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_STORE, S_NEXT
    } state_t;

    state_t        state, state_nxt;
    logic [23:0]   period_cnt;
    logic          tick;
    logic [3:0]    idx;
    logic [TW-1:0] timer;
    logic          timer_done;

    logic set_start, clr_start, timer_load, err_inc, push_req;
    logic idx_inc, idx_clr, round_start, reg_load;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0] count;
    logic          full_i, empty_i, do_push, do_pop, drop;
    logic [EW-1:0] push_data;

    assign wr_rd_flag      = 1'b1;
    assign data_byte       = 8'h00;
    assign i2c_device_addr = DEV_ADDR;
    assign poll_active     = (state != S_IDLE);

    assign tick       = enable && (period_cnt == 24'(POLL_DIV - 1));
    assign timer_done = (timer == '0);

    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n)
            period_cnt <= '0;
        else if (!enable || tick)
            period_cnt <= '0;
        else
            period_cnt <= period_cnt + 24'd1;
    end

    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        set_start   = 1'b0;
        clr_start   = 1'b0;
        timer_load  = 1'b0;
        err_inc     = 1'b0;
        push_req    = 1'b0;
        idx_inc     = 1'b0;
        idx_clr     = 1'b0;
        round_start = 1'b0;
        reg_load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    idx_clr     = 1'b1;
                    round_start = 1'b1;
                    state_nxt   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                reg_load   = 1'b1;
                set_start  = 1'b1;
                timer_load = 1'b1;
                state_nxt  = S_WAIT_HI;
            end
            // busy wins over a timeout expiring in the same cycle
            S_WAIT_HI: begin
                if (busy) begin
                    clr_start  = 1'b1;
                    timer_load = 1'b1;
                    state_nxt  = S_WAIT_LO;
                end else if (timer_done) begin
                    clr_start = 1'b1;
                    err_inc   = 1'b1;
                    state_nxt = S_NEXT;
                end
            end
            S_WAIT_LO: begin
                if (!busy) begin
                    state_nxt = S_STORE;
                end else if (timer_done) begin
                    err_inc   = 1'b1;
                    state_nxt = S_NEXT;
                end
            end
            S_STORE: begin
                if (err)
                    err_inc = 1'b1;
                else
                    push_req = 1'b1;
                state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (idx == 4'(NUM_REGS - 1) || !enable) begin
                    idx_clr   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    idx_inc   = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Timer loads TIMEOUT-1 so a phase lasts exactly TIMEOUT cycles before giving up
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            timer    <= '0;
            start_en <= 1'b0;
            idx      <= '0;
            register <= REG_BASE;
            err_cnt  <= '0;
        end else begin
            if (timer_load)
                timer <= TW'(TIMEOUT - 1);
            else if ((state == S_WAIT_HI || state == S_WAIT_LO) && !timer_done)
                timer <= timer - 1'b1;
            if (set_start)
                start_en <= 1'b1;
            else if (clr_start)
                start_en <= 1'b0;
            if (idx_clr)
                idx <= '0;
            else if (idx_inc)
                idx <= idx + 4'd1;
            if (reg_load)
                register <= REG_BASE + {12'd0, idx};
            if (err_inc && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

`ifdef IIC_POLL_ROUND_STAMP_EN
    logic [15:0] round_cnt;
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n)
            round_cnt <= '0;
        else if (round_start)
            round_cnt <= round_cnt + 16'd1;
    end
    assign push_data = {round_cnt, register, rd_data};
`else
    assign push_data = {register, rd_data};
`endif

    assign full_i  = (count == CW'(FIFO_DEPTH));
    assign empty_i = (count == '0);
    assign do_pop  = fifo_rd && !empty_i;
    assign do_push = push_req && (!full_i || do_pop);
    assign drop    = push_req && full_i && !do_pop;
    assign rd_nxt  = rd_ptr + 1'b1;

    assign fifo_full  = full_i;
    assign fifo_empty = empty_i;
    assign fifo_count = count;

    always_ff @(posedge clk_8m) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Head register: bypass the push when the FIFO holds at most the entry being popped
    always_ff @(posedge clk_8m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            fifo_dout    <= '0;
            overflow_cnt <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_nxt;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
            if (do_pop) begin
                if (count > CW'(1))
                    fifo_dout <= mem[rd_nxt];
                else if (do_push)
                    fifo_dout <= push_data;
            end else if (do_push && empty_i) begin
                fifo_dout <= push_data;
            end
            if (drop && overflow_cnt != 8'hFF)
                overflow_cnt <= overflow_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_iic_poll_reader.sv
// Directed bench for iic_poll_reader with a behavioural iic_drive responder.
`timescale 1ns/1ps

module tb_iic_poll_reader;

    localparam int P_DIV = 200;
    localparam int T_OUT = 30;
`ifdef IIC_POLL_ROUND_STAMP_EN
    localparam int EW = 40;
`else
    localparam int EW = 24;
`endif

    logic          clk_8m = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          busy, err;
    logic [7:0]    rd_data;
    logic          start_en, wr_rd_flag;
    logic [7:0]    i2c_device_addr, data_byte;
    logic [15:0]   register;
    logic          fifo_rd = 1'b0;
    logic [EW-1:0] fifo_dout;
    logic          fifo_empty, fifo_full, poll_active;
    logic [3:0]    fifo_count;
    logic [7:0]    err_cnt, overflow_cnt;

    bit          silent = 1'b0;
    bit          err_on = 1'b0;
    logic [15:0] err_reg = 16'h0000;
    int          checks = 0;
    int          failures = 0;

    iic_poll_reader #(
        .NUM_REGS(4), .POLL_DIV(P_DIV), .TIMEOUT(T_OUT), .FIFO_DEPTH(8)
    ) dut (
        .clk_8m(clk_8m), .rst_n(rst_n), .enable(enable), .busy(busy), .err(err),
        .rd_data(rd_data), .start_en(start_en), .wr_rd_flag(wr_rd_flag),
        .i2c_device_addr(i2c_device_addr), .register(register), .data_byte(data_byte),
        .fifo_rd(fifo_rd), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_count(fifo_count), .err_cnt(err_cnt),
        .overflow_cnt(overflow_cnt), .poll_active(poll_active)
    );

    always #62.5 clk_8m = ~clk_8m;

    // iic_drive model: busy rises 3 cycles after start_en, stays 5 cycles, data A0+reg offset
    initial begin
        busy = 1'b0; err = 1'b0; rd_data = 8'h00;
        forever begin
            @(posedge clk_8m); #1;
            if (rst_n && start_en && !silent && !busy) begin
                repeat (3) @(posedge clk_8m);
                #1;
                busy    = 1'b1;
                rd_data = 8'hA0 + register[7:0];
                err     = err_on && (register == err_reg);
                repeat (5) @(posedge clk_8m);
                #1;
                busy = 1'b0;
            end
        end
    end

    task automatic wait_active(input logic level, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_8m); #1;
            if (poll_active === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_round(output bit ok);
        bit a, b;
        wait_active(1'b1, P_DIV + 10, a);
        wait_active(1'b0, 4 * (T_OUT + 10) + 20, b);
        ok = a && b;
    endtask

    task automatic pop_cycle();
        fifo_rd = 1'b1;
        @(posedge clk_8m); #1;
        fifo_rd = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_8m);
        #1;
        checks++;
        if (start_en !== 1'b0 || wr_rd_flag !== 1'b1 || i2c_device_addr !== 8'h78 || data_byte !== 8'h00) begin
            failures++;
            $display("FAIL reset_cmd: start_en=%b wr_rd=%b addr=%h data=%h want 0 1 78 00", start_en, wr_rd_flag, i2c_device_addr, data_byte);
        end
        checks++;
        if (register !== 16'h3000 || poll_active !== 1'b0) begin
            failures++;
            $display("FAIL reset_reg: register=%h poll_active=%b want 3000 0", register, poll_active);
        end
        checks++;
        if (fifo_dout !== '0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_fifo: dout=%h empty=%b full=%b count=%0d want 0 1 0 0", fifo_dout, fifo_empty, fifo_full, fifo_count);
        end
        checks++;
        if (err_cnt !== 8'd0 || overflow_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_cnt: err_cnt=%0d overflow_cnt=%0d want 0 0", err_cnt, overflow_cnt);
        end
        @(negedge clk_8m);
        rst_n = 1'b1;
    endtask

    task automatic test_round();
        logic [23:0] exp [4];
        bit a, b;
        exp = '{24'h3000A0, 24'h3001A1, 24'h3002A2, 24'h3003A3};
        @(posedge clk_8m); #1;
        enable = 1'b1;
        wait_active(1'b1, P_DIV + 10, a);
        wait_active(1'b0, 200, b);
        enable = 1'b0;
        checks++;
        if (!(a && b)) begin
            failures++;
            $display("FAIL round_timing: rise_seen=%b fall_seen=%b want 1 1", a, b);
        end
        checks++;
        if (fifo_count !== 4'd4 || err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL round_count: count=%0d err_cnt=%0d at poll_active fall want 4 0", fifo_count, err_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (fifo_dout[23:0] !== exp[i]) begin
                failures++;
                $display("FAIL round_entry%0d: got %h want %h", i, fifo_dout[23:0], exp[i]);
            end
            pop_cycle();
        end
        checks++;
        if (fifo_empty !== 1'b1) begin
            failures++;
            $display("FAIL round_drain: empty=%b want 1", fifo_empty);
        end
    endtask

    task automatic test_err();
        logic [23:0] exp [3];
        bit ok;
        exp = '{24'h3000A0, 24'h3001A1, 24'h3003A3};
        err_on = 1'b1; err_reg = 16'h3002;
        enable = 1'b1;
        wait_round(ok);
        enable = 1'b0;
        err_on = 1'b0;
        checks++;
        if (!ok || fifo_count !== 4'd3 || err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL err_round: done=%b count=%0d err_cnt=%0d want 1 3 1", ok, fifo_count, err_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fifo_dout[23:0] !== exp[i]) begin
                failures++;
                $display("FAIL err_entry%0d: got %h want %h", i, fifo_dout[23:0], exp[i]);
            end
            pop_cycle();
        end
    endtask

    task automatic test_timeout();
        int hi;
        bit seen, ok;
        silent = 1'b1;
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < P_DIV + 10; i++) begin
            @(posedge clk_8m); #1;
            if (start_en) begin
                seen = 1'b1;
                break;
            end
        end
        hi = seen ? 1 : 0;
        for (int i = 0; i < 3 * T_OUT && seen; i++) begin
            @(posedge clk_8m); #1;
            if (start_en) hi++;
            else break;
        end
        checks++;
        if (hi != T_OUT) begin
            failures++;
            $display("FAIL timeout_width: start_en high %0d cycles want %0d", hi, T_OUT);
        end
        checks++;
        if (err_cnt !== 8'd2) begin
            failures++;
            $display("FAIL timeout_first_err: err_cnt=%0d want 2", err_cnt);
        end
        wait_active(1'b0, 4 * (T_OUT + 10), ok);
        enable = 1'b0;
        silent = 1'b0;
        checks++;
        if (!ok || err_cnt !== 8'd5 || fifo_count !== 4'd0) begin
            failures++;
            $display("FAIL timeout_round: done=%b err_cnt=%0d count=%0d want 1 5 0", ok, err_cnt, fifo_count);
        end
    endtask

    task automatic test_overflow();
        logic [23:0] exp [8];
        bit ok, a, seen_hi, found;
        exp = '{24'h3001A1, 24'h3002A2, 24'h3003A3, 24'h3000A0,
                24'h3001A1, 24'h3002A2, 24'h3003A3, 24'h3000A0};
        enable = 1'b1;
        for (int r = 0; r < 3; r++) begin
            wait_round(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL ovf_round%0d: round did not complete", r);
            end
        end
        checks++;
        if (fifo_full !== 1'b1 || fifo_count !== 4'd8 || overflow_cnt !== 8'd4) begin
            failures++;
            $display("FAIL ovf_full: full=%b count=%0d overflow=%0d want 1 8 4", fifo_full, fifo_count, overflow_cnt);
        end
        // fourth round: pop exactly in the STORE cycle of register 3000
        wait_active(1'b1, P_DIV + 10, a);
        seen_hi = 1'b0; found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_8m);
            if (busy) seen_hi = 1'b1;
            else if (seen_hi) begin
                found = 1'b1;
                break;
            end
        end
        @(posedge clk_8m); #1;
        fifo_rd = 1'b1;
        @(posedge clk_8m); #1;
        fifo_rd = 1'b0;
        enable = 1'b0;
        checks++;
        if (!(a && found) || fifo_count !== 4'd8 || overflow_cnt !== 8'd4 || fifo_dout[23:0] !== 24'h3001A1) begin
            failures++;
            $display("FAIL ovf_pushpop: sync=%b count=%0d overflow=%0d head=%h want 1 8 4 3001a1", a && found, fifo_count, overflow_cnt, fifo_dout[23:0]);
        end
        wait_active(1'b0, 40, ok);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (fifo_dout[23:0] !== exp[i]) begin
                failures++;
                $display("FAIL ovf_entry%0d: got %h want %h", i, fifo_dout[23:0], exp[i]);
            end
            pop_cycle();
        end
        pop_cycle();
        checks++;
        if (fifo_count !== 4'd0 || fifo_empty !== 1'b1) begin
            failures++;
            $display("FAIL ovf_empty_pop: count=%0d empty=%b want 0 1", fifo_count, fifo_empty);
        end
    endtask

    task automatic test_enable_drop();
        bit a, found, ok;
        int starts;
        enable = 1'b1;
        wait_active(1'b1, P_DIV + 10, a);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_8m);
            if (register == 16'h3001 && busy) begin
                found = 1'b1;
                break;
            end
        end
        @(negedge clk_8m);
        enable = 1'b0;
        wait_active(1'b0, 40, ok);
        checks++;
        if (!(a && found && ok) || fifo_count !== 4'd2 || register !== 16'h3001) begin
            failures++;
            $display("FAIL drop_stop: sync=%b count=%0d register=%h want 1 2 3001", a && found && ok, fifo_count, register);
        end
        starts = 0;
        repeat (20) begin
            @(posedge clk_8m); #1;
            if (start_en || poll_active) starts++;
        end
        checks++;
        if (starts != 0 || register !== 16'h3001) begin
            failures++;
            $display("FAIL drop_idle: active cycles=%0d register=%h want 0 3001", starts, register);
        end
        checks++;
        if (fifo_dout[23:0] !== 24'h3000A0) begin
            failures++;
            $display("FAIL drop_entry0: got %h want 3000a0", fifo_dout[23:0]);
        end
        pop_cycle();
        checks++;
        if (fifo_dout[23:0] !== 24'h3001A1) begin
            failures++;
            $display("FAIL drop_entry1: got %h want 3001a1", fifo_dout[23:0]);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        silent = 1'b1;
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < P_DIV + 10; i++) begin
            @(posedge clk_8m); #1;
            if (start_en) begin
                seen = 1'b1;
                break;
            end
        end
        repeat (5) @(posedge clk_8m);
        @(negedge clk_8m);
        rst_n = 1'b0;
        #1;
        checks++;
        if (!seen || start_en !== 1'b0 || poll_active !== 1'b0 || register !== 16'h3000) begin
            failures++;
            $display("FAIL rstmid_cmd: seen=%b start_en=%b poll_active=%b register=%h want 1 0 0 3000", seen, start_en, poll_active, register);
        end
        checks++;
        if (fifo_count !== 4'd0 || fifo_empty !== 1'b1 || fifo_dout !== '0 || err_cnt !== 8'd0 || overflow_cnt !== 8'd0) begin
            failures++;
            $display("FAIL rstmid_state: count=%0d empty=%b dout=%h err=%0d ovf=%0d want 0 1 0 0 0", fifo_count, fifo_empty, fifo_dout, err_cnt, overflow_cnt);
        end
        @(negedge clk_8m);
        enable = 1'b0;
        silent = 1'b0;
        rst_n = 1'b1;
    endtask

`ifdef IIC_POLL_ROUND_STAMP_EN
    task automatic test_round_stamp();
        logic [15:0] exp_stamp;
        logic [23:0] exp_body;
        bit ok1, ok2;
        enable = 1'b1;
        wait_round(ok1);
        wait_round(ok2);
        enable = 1'b0;
        checks++;
        if (!(ok1 && ok2) || fifo_count !== 4'd8) begin
            failures++;
            $display("FAIL stamp_rounds: done=%b count=%0d want 1 8", ok1 && ok2, fifo_count);
        end
        for (int i = 0; i < 8; i++) begin
            exp_stamp = (i < 4) ? 16'h0001 : 16'h0002;
            exp_body  = 24'h3000A0 + 24'((i % 4) * 24'h000101);
            checks++;
            if (fifo_dout[39:24] !== exp_stamp || fifo_dout[23:0] !== exp_body) begin
                failures++;
                $display("FAIL stamp_entry%0d: got %h want %h%h", i, fifo_dout, exp_stamp, exp_body);
            end
            pop_cycle();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round();
        test_err();
        test_timeout();
        test_overflow();
        test_enable_drop();
        test_reset_mid();
`ifdef IIC_POLL_ROUND_STAMP_EN
        test_round_stamp();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iic_poll_reader.md
Name: iic_poll_reader

Overview:
- Periodic register poller that sits directly upstream of iic_drive.
- Drives iic_drive's command inputs (wr_rd_flag, start_en, i2c_device_addr, register, data_byte) to read a contiguous block of device registers every poll period.
- Consumes iic_drive's busy/err/rd_data.
- Pushes {register, data} results into an internal FIFO for a downstream consumer. Shares the iic_drive command bus with iic_reg_init through an external mux; only this block is active while enable=1.

Parameters:
- DEV_ADDR, 8'h78: i2c_device_addr driven on every transaction.
- REG_BASE, 16'h3000: first register polled.
- NUM_REGS, 4: registers per round (1..16); index wraps to 0 after NUM_REGS-1.
- POLL_DIV, 80000: clk_8m cycles between round starts (10 ms at 8 MHz); 24-bit counter.
- TIMEOUT, 20000: max clk_8m cycles per handshake phase.
- FIFO_DEPTH, 8: result FIFO entries (power of 2).

Ports:
- clk_8m  in  1  system clock
- rst_n  in  1  async reset, active-low
- enable  in  1  level; 1 = polling runs
- busy  in  1  from iic_drive
- err  in  1  from iic_drive, valid when busy falls
- rd_data  in  8  from iic_drive, valid when busy falls
- start_en  out  1  to iic_drive
- wr_rd_flag  out  1  to iic_drive; constant 1 (read)
- i2c_device_addr  out  8  to iic_drive
- register  out  16  to iic_drive
- data_byte  out  8  to iic_drive; constant 0
- fifo_rd  in  1  pop request
- fifo_dout  out  24  head entry {register[15:0], data[7:0]}, first-word-fall-through
- fifo_empty  out  1
- fifo_full  out  1
- fifo_count  out  $clog2(FIFO_DEPTH)+1
- err_cnt  out  8  saturating NACK/timeout counter
- overflow_cnt  out  8  saturating dropped-result counter
- poll_active  out  1  high while a round is in progress

Behaviour:
- Reset values: start_en=0, wr_rd_flag=1, i2c_device_addr=DEV_ADDR, register=REG_BASE, data_byte=0, fifo_dout=0, fifo_empty=1, fifo_full=0, fifo_count=0, err_cnt=0, overflow_cnt=0, poll_active=0; FSM=IDLE, index=0, period counter=0.
- Timing:
  - busy is sampled directly in clk_8m. It is generated from clk_i, which is derived synchronously from clk_8m (20 clk_8m cycles per clk_i period), so no synchroniser is used.
  - start_en is a level, held until busy is observed, because iic_drive samples it on clk_i.
- Period counter: free-runs 0..POLL_DIV-1 while enable=1 and wraps. Wrap generates a tick. Counter is held at 0 while enable=0.
- FSM states:
  - IDLE: on tick with enable=1 -> ISSUE; set poll_active=1, index=0.
  - ISSUE: register <= REG_BASE+index; next cycle start_en=1 -> WAIT_HI; phase timer cleared.
  - WAIT_HI: on busy=1 -> start_en=0, -> WAIT_LO. On timer==TIMEOUT -> start_en=0, err_cnt++, -> NEXT.
  - WAIT_LO: on busy=0 -> STORE. On timer==TIMEOUT -> err_cnt++, -> NEXT. Timer restarts on entry.
  - STORE (1 cycle):
    - err=1: err_cnt++, no write.
    - Otherwise write {register, rd_data}.
    - If FIFO full and no simultaneous pop: drop, overflow_cnt++.
    - -> NEXT.
  - NEXT:
    - index==NUM_REGS-1 or enable=0 -> IDLE, poll_active=0, index=0.
    - Otherwise index++, -> ISSUE.
- Ticks arriving while not in IDLE are ignored; no queuing.
- enable falling mid-transaction: the current transaction completes, including STORE; then -> IDLE.
- Counters saturate at 8'hFF.
- FIFO:
  - Push and pop in the same cycle: both execute, fifo_count unchanged. When full, a simultaneous push and pop succeeds.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_dout updates the cycle after a pop, or after the first write into an empty FIFO.
- Reset mid-operation: everything returns to reset values immediately; start_en drops asynchronously; FIFO contents are discarded.

Optional Feature:
- Macro IIC_POLL_ROUND_STAMP_EN.
- Defined:
  - fifo_dout widens to 40 bits as {round_cnt[15:0], register, data}.
  - round_cnt is a 16-bit wrapping counter, incremented on each IDLE->ISSUE transition, reset 0.
  - FIFO storage widens to match.
- Undefined: fifo_dout is 24 bits; no round counter logic.

Test Plan:
- enable=1, NUM_REGS=4, model answers 8'hA0..8'hA3 with err=0 -> after one tick, FIFO holds 24'h3000A0, 24'h3001A1, 24'h3002A2, 24'h3003A3 in order; fifo_count=4; poll_active falls after 4th STORE.
- Model sets err=1 on register 16'h3002 -> 3 entries only, err_cnt=1, index continues to 16'h3003.
- Model never raises busy -> start_en high for exactly TIMEOUT cycles then 0, err_cnt=1 per register, 4 after one round, no FIFO writes.
- No pops for 3 rounds (12 results, FIFO_DEPTH=8) -> fifo_full=1, fifo_count=8, overflow_cnt=4. Then pop with simultaneous push when full -> count stays 8, oldest entry leaves.
- enable dropped during WAIT_LO of register 16'h3001 -> that result stored, no ISSUE for 16'h3002, FSM IDLE. rst_n pulsed mid-WAIT_HI -> start_en=0 and all outputs at reset values within the same cycle.
- IIC_POLL_ROUND_STAMP_EN defined, two rounds -> entries carry round_cnt 16'h0001 then 16'h0002 in fifo_dout[39:24].
